// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: multi-digit hex seven-segment display controller.
// A written word goes into a shadow buffer and is committed to the display register only at a
// safe point. In static mode that is the next cycle. In scan mode it is the end of a frame.
// Because of this, the display never shows half of an old value and half of a new one.
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   wr_en, wr_data         write request and packed nibbles (digit 0 in [3:0])
//   wr_ready               shadow buffer free (a write is accepted when wr_en & wr_ready)
//   mode_scan              0: static outputs, 1: multiplexed scan
//   lz_suppress            blank leading zero digits (digit 0 is never suppressed)
//   blank_mask, blink_mask per-digit force-off / off-during-blink-off-phase
//   dp_in                  per-digit decimal point
//   seg_static, dp_static  per-digit segment buses (gfedcba) for static mode
//   seg_scan, dp_scan      shared segment bus for scan mode
//   dig_sel                one-hot digit enable for scan mode
// All display outputs are registered. Polarity is set by ACTIVE_LOW.
module seg7_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    mode_scan,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7*NUM_DIGITS-1:0] seg_static,
  output logic [NUM_DIGITS-1:0]   dp_static,
  output logic [6:0]              seg_scan,
  output logic                    dp_scan,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  // Hex to gfedcba, 1 = segment lit.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_q, disp_q;
  logic                    pending_q;
  logic                    mode_q;
  logic [ScanW-1:0]        scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]         scan_idx_q, scan_idx_d;
  logic [BlinkW-1:0]       blink_cnt_q;
  logic                    blink_on_q;

  // Output registers hold the active-high ("lit") view; polarity is applied at the pins.
  logic [7*NUM_DIGITS-1:0] seg_static_q, seg_static_d;
  logic [NUM_DIGITS-1:0]   dp_static_q, dp_static_d;
  logic [6:0]              seg_scan_q, seg_scan_d;
  logic                    dp_scan_q, dp_scan_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic                        frame_end, commit, accept;
  logic                        zero_above;
  logic [NUM_DIGITS-1:0]       blanked;
  logic [NUM_DIGITS-1:0][6:0]  seg_lit;
  logic [NUM_DIGITS-1:0]       dp_lit;

  assign wr_ready  = ~pending_q;
  assign accept    = wr_en & ~pending_q;
  assign frame_end = (scan_idx_q == IdxW'(NUM_DIGITS - 1)) &&
                     (scan_cnt_q == ScanW'(SCAN_DIV - 1));
  // Outside scan mode the counters sit at 0, so frame_end cannot fire there or on a mode switch.
  assign commit    = pending_q & (~mode_scan | frame_end);

  // The scan counters restart on any mode change and stay parked while in static mode.
  always_comb begin
    scan_cnt_d = '0;
    scan_idx_d = '0;
    if (mode_scan && mode_q) begin
      if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
        scan_cnt_d = '0;
        scan_idx_d = (scan_idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
      end
    end
  end

  // Per-digit blanking and decode. zero_above accumulates from the top digit downwards.
  always_comb begin
    zero_above = 1'b1;
    blanked    = '0;
    seg_lit    = '0;
    dp_lit     = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (disp_q[4*i +: 4] == 4'h0);
      blanked[i] = blank_mask[i] | (blink_mask[i] & ~blink_on_q) |
                   (lz_suppress & (i != 0) & zero_above);
      seg_lit[i] = blanked[i] ? 7'h00 : hex_decode(disp_q[4*i +: 4]);
      dp_lit[i]  = ~blanked[i] & dp_in[i];
    end
  end

  always_comb begin
    seg_static_d = '0;
    dp_static_d  = '0;
    seg_scan_d   = '0;
    dp_scan_d    = 1'b0;
    dig_sel_d    = '0;
    if (mode_scan) begin
      seg_scan_d = seg_lit[scan_idx_q];
      dp_scan_d  = dp_lit[scan_idx_q];
      dig_sel_d  = NUM_DIGITS'(1) << scan_idx_q;
    end else begin
      seg_static_d = seg_lit;
      dp_static_d  = dp_lit;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      mode_q       <= 1'b0;
      scan_cnt_q   <= '0;
      scan_idx_q   <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      seg_static_q <= '0;
      dp_static_q  <= '0;
      seg_scan_q   <= '0;
      dp_scan_q    <= 1'b0;
      dig_sel_q    <= '0;
    end else begin
      // commit and accept are mutually exclusive: accept needs an empty shadow.
      if (commit) begin
        disp_q    <= shadow_q;
        pending_q <= 1'b0;
      end else if (accept) begin
        shadow_q  <= wr_data;
        pending_q <= 1'b1;
      end
      mode_q     <= mode_scan;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      seg_static_q <= seg_static_d;
      dp_static_q  <= dp_static_d;
      seg_scan_q   <= seg_scan_d;
      dp_scan_q    <= dp_scan_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  assign seg_static = seg_static_q ^ {(7*NUM_DIGITS){ACTIVE_LOW}};
  assign dp_static  = dp_static_q ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign seg_scan   = seg_scan_q ^ {7{ACTIVE_LOW}};
  assign dp_scan    = dp_scan_q ^ ACTIVE_LOW;
  assign dig_sel    = dig_sel_q ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl (4 digits, SCAN_DIV=4, BLINK_DIV=16, active-low).
// A time-based reference model predicts every registered output each cycle. Directed literal
// checks cover the worked examples.
module tb_seg7_display_ctrl;
  localparam int N = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          mode_scan, lz_suppress;
  logic [3:0]    blank_mask, blink_mask, dp_in;
  logic [27:0]   seg_static;
  logic [3:0]    dp_static;
  logic [6:0]    seg_scan;
  logic          dp_scan;
  logic [3:0]    dig_sel;

  int tests = 0;
  int fails = 0;

  seg7_display_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b1)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .mode_scan(mode_scan), .lz_suppress(lz_suppress), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .dp_in(dp_in), .seg_static(seg_static), .dp_static(dp_static),
    .seg_scan(seg_scan), .dp_scan(dp_scan), .dig_sel(dig_sel)
  );

  always #5 HCLK = ~HCLK;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: time counters rather than prescaler registers.
  int         m_cyc, m_scan_t;
  bit         m_mode_prev, m_pend;
  logic [15:0] m_disp, m_shadow;

  logic [27:0] e_seg_static;
  logic [3:0]  e_dp_static, e_dig_sel;
  logic [6:0]  e_seg_scan;
  logic        e_dp_scan;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    int  idx;
    bit  on, blank;
    logic [6:0] lit [N];
    bit  dpl [N];
    idx = (m_scan_t / 4) % N;
    on  = ((m_cyc / 16) % 2) == 0;
    for (int i = 0; i < N; i++) begin
      blank = blank_mask[i] || (blink_mask[i] && !on) ||
              (lz_suppress && i > 0 && ((m_disp >> (4*i)) == 0));
      lit[i] = blank ? 7'h00 : tbl[(m_disp >> (4*i)) & 16'hF];
      dpl[i] = !blank && dp_in[i];
    end
    e_seg_static = '1; e_dp_static = '1; e_seg_scan = '1; e_dp_scan = 1'b1; e_dig_sel = '1;
    if (!HRESET) begin
      if (mode_scan) begin
        e_seg_scan = ~lit[idx];
        e_dp_scan  = ~dpl[idx];
        e_dig_sel  = ~(4'b0001 << idx);
      end else begin
        for (int i = 0; i < N; i++) begin
          e_seg_static[7*i +: 7] = ~lit[i];
          e_dp_static[i]         = ~dpl[i];
        end
      end
    end
  endtask

  task automatic advance_model();
    bit frame_end, commit, accept;
    if (HRESET) begin
      m_cyc = 0; m_scan_t = 0; m_mode_prev = 0; m_pend = 0; m_disp = '0; m_shadow = '0;
      return;
    end
    frame_end = mode_scan && (m_mode_prev == mode_scan) && ((m_scan_t % 16) == 15);
    commit    = m_pend && (!mode_scan || frame_end);
    accept    = wr_en && !m_pend;
    if (commit) begin
      m_disp = m_shadow; m_pend = 0;
    end else if (accept) begin
      m_shadow = wr_data; m_pend = 1;
    end
    m_scan_t    = (mode_scan && m_mode_prev == mode_scan) ? m_scan_t + 1 : 0;
    m_mode_prev = mode_scan;
    m_cyc++;
  endtask

  // One clock: predict from pre-edge state, clock, then check just after the edge.
  task automatic tick();
    predict();
    @(posedge HCLK);
    advance_model();
    #1;
    chk("seg_static", seg_static, e_seg_static);
    chk("dp_static", dp_static, e_dp_static);
    chk("seg_scan", seg_scan, e_seg_scan);
    chk("dp_scan", dp_scan, e_dp_scan);
    chk("dig_sel", dig_sel, e_dig_sel);
    chk("wr_ready", wr_ready, !m_pend);
  endtask

  initial begin
    logic [27:0] lit28;
    logic [6:0]  want;
    HRESET = 1; wr_en = 0; wr_data = '0; mode_scan = 0; lz_suppress = 0;
    blank_mask = '0; blink_mask = '0; dp_in = '0;
    #1;
    tick(); tick();
    chk("reset_seg_static", seg_static, 28'hFFFFFFF);
    chk("reset_dig_sel", dig_sel, 4'hF);
    chk("reset_wr_ready", wr_ready, 1'b1);
    HRESET = 0;

    // Static write: ready low for exactly one cycle, pattern two cycles after acceptance.
    wr_en = 1; wr_data = 16'hA5F0; tick();
    chk("static_ready_low", wr_ready, 1'b0);
    wr_en = 0; tick();
    chk("static_ready_back", wr_ready, 1'b1);
    tick();
    lit28 = {~7'h77, ~7'h6D, ~7'h71, ~7'h3F};
    chk("static_A5F0", seg_static, lit28);

    // Leading-zero suppression.
    lz_suppress = 1; wr_en = 1; wr_data = 16'h0070; tick(); wr_en = 0; tick(); tick();
    lit28 = {7'h7F, 7'h7F, ~7'h07, ~7'h3F};
    chk("lz_0070", seg_static, lit28);
    wr_en = 1; wr_data = 16'h0000; tick(); wr_en = 0; tick(); tick();
    lit28 = {7'h7F, 7'h7F, 7'h7F, ~7'h3F};
    chk("lz_0000", seg_static, lit28);
    lz_suppress = 0;

    // Scan mode showing 1234.
    wr_en = 1; wr_data = 16'h1234; tick(); wr_en = 0; tick();
    mode_scan = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("static_off_in_scan", seg_static, 28'hFFFFFFF);
      case (dig_sel)
        4'b1110: want = ~7'h66;
        4'b1101: want = ~7'h4F;
        4'b1011: want = ~7'h5B;
        4'b0111: want = ~7'h06;
        default: want = 7'h7F;
      endcase
      if (c > 1) chk("scan_1234", seg_scan, want);
    end

    // Mid-frame write then an ignored second write; the old value holds until frame end.
    wr_en = 1; wr_data = 16'hFFFF; tick();
    wr_data = 16'h5555; tick();
    wr_en = 0;
    repeat (40) tick();

    // Blink and blank.
    blink_mask = 4'b0001; blank_mask = 4'b0100; dp_in = 4'b1111;
    repeat (40) tick();
    mode_scan = 0;
    repeat (40) tick();
    blink_mask = '0; blank_mask = '0;

    // Reset during a pending scan-mode write.
    mode_scan = 1; repeat (3) tick();
    wr_en = 1; wr_data = 16'h9876; tick(); wr_en = 0;
    HRESET = 1; tick();
    chk("rst_mid_seg_scan", seg_scan, 7'h7F);
    chk("rst_mid_dig_sel", dig_sel, 4'hF);
    chk("rst_mid_ready", wr_ready, 1'b1);
    HRESET = 0;
    repeat (40) tick();

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 16'($urandom);
      if ($urandom_range(0, 39) == 0) mode_scan = ~mode_scan;
      if ($urandom_range(0, 19) == 0) begin
        blank_mask  = 4'($urandom);
        blink_mask  = 4'($urandom);
        dp_in       = 4'($urandom);
        lz_suppress = 1'($urandom);
      end
      HRESET = ($urandom_range(0, 149) == 0);
      tick();
    end
    HRESET = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
